reflet_mem_access_seq: RTL and testbench
========================================

// Module: reflet_mem_access_seq
// PURPOSE
//  Memory access sequencer between the CPU data path (after width reduction) and a
//  single-port synchronous RAM with fixed read latency. Runs full-word reads/writes and
//  the read-modify-write a narrow store needs, so upper RAM bits are preserved.
//  Handshakes with the CPU by holding a request until a one-cycle ready pulse.
// PARAMETERS
//  wordsize     16  CPU/RAM data and address width (8,16,32,64,128)
//  ram_latency   1  cycles from ram_en sampled to ram_rdata valid (1..15)
// PORTS
//  clk          in   1         clock
//  reset        in   1         synchronous, active-low
//  cpu_req      in   1         access request, held until cpu_ready
//  cpu_we       in   1         1 = write, 0 = read
//  cpu_size     in   2         reduced-behaviour bits: 00 full, 01 32b, 10 16b, 11 8b
//  cpu_addr     in   wordsize  word address
//  cpu_wdata    in   wordsize  write data, low bits significant when narrow
//  cpu_rdata    out  wordsize  read data, zero-extended when narrow
//  cpu_ready    out  1         one-cycle pulse: access complete
//  ram_en       out  1         RAM access strobe
//  ram_we       out  1         RAM write enable, only together with ram_en
//  ram_addr     out  wordsize  RAM address
//  ram_wdata    out  wordsize  RAM write data
//  ram_rdata    in   wordsize  RAM read data
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE. All outputs 0, latency counter 0.
//  Reset mid-access aborts it: no further RAM strobe, no ready pulse.
//  Narrow: cpu_size!=00 and selected width < wordsize. Otherwise full; cpu_size ignored.
//  Mask width n = 32/16/8 for cpu_size 01/10/11.
//  On accept, addr/we/size/wdata are latched. Later cpu_* changes have no effect.
//  FSM:
//   IDLE  : cpu_req=1 -> latch inputs
//           -> WRITE if we and full; else RD_ISSUE.
//   RD_ISSUE : ram_en=1, ram_we=0 for one cycle; load counter=ram_latency -> RD_WAIT.
//   RD_WAIT  : decrement counter each cycle.
//           At 0, capture ram_rdata into rbuf, then:
//             read  -> DONE, cpu_rdata = rbuf masked to n bits (full: unmasked)
//             write -> WRITE, merge = {rbuf[wordsize-1:n], wdata[n-1:0]}.
//   WRITE : ram_en=1, ram_we=1, ram_wdata = wdata (full) or merge (narrow),
//           one cycle -> DONE.
//   DONE  : cpu_ready=1 one cycle, cpu_rdata stable -> IDLE.
//           cpu_req is not sampled in DONE.
//  Latency, accept edge to ready-high cycle:
//   full write          = 2 cycles
//   read                = ram_latency+3 cycles
//   narrow write (RMW)  = ram_latency+4 cycles
//  cpu_rdata holds its last value until the next read completes. It is 0 after reset.
//  ram_addr holds the latched address from RD_ISSUE through WRITE. It is 0 while IDLE.
//  ram_wdata is 0 except in WRITE.
//  cpu_req held high after ready is taken as a new request, accepted on the IDLE cycle.
//   Back-to-back throughput is therefore one access per latency+1 cycles.
//  ram_en is never asserted in two consecutive cycles of one access except RD_WAIT->WRITE
//   boundary (not consecutive: RD_WAIT strobes nothing).
//  Counter width 4 bits. ram_latency=0 is not supported (lint error via generate check).
// STRUCTURE
//  Shared package/header reflet.vh: state encodings
//   RMS_IDLE, RMS_RD_ISSUE, RMS_RD_WAIT, RMS_WRITE, RMS_DONE,
//   plus cpu_size encodings (same values as reduced-behaviour bits).
//  Sub-module reflet_width_mask (combinational): (size, wordsize) -> narrow flag and
//   mask vector. It is reused for both the read zero-extend and the write merge.
//  FSM, counter and latch registers stay in the top module.
// TESTING
//  All with wordsize=32, ram_latency=2, RAM model with 2-cycle read latency.
//  Full read: mem[0x10]=0xDEADBEEF, read addr 0x10 size 00
//   -> ready 5 cycles after accept, rdata=0xDEADBEEF.
//  Byte write RMW: mem[0x20]=0x11223344, write 0xAAAAAA55 size 11
//   -> one read strobe then one write strobe of 0x11223355; ready at cycle 6.
//  Half read: mem[0x30]=0xCAFEBABE, read size 10 -> rdata=0x0000BABE.
//  size 01 on wordsize=32: write 0x12345678 -> single write strobe, no read, ready at cycle 2.
//  Reset in RD_WAIT: assert reset one cycle in
//   -> no WRITE strobe, no ready, all outputs 0, next access normal.
//  Held cpu_req: two reads back-to-back -> two ready pulses, separated by one IDLE cycle.

Source files
------------

// File: rtl/reflet_mem_access_seq_pkg.sv
// Shared definitions for the memory access sequencer.
//  - rms_state_t : sequencer FSM states
//  - SIZE_*      : cpu_size encodings (the CPU's reduced-behaviour bits)
//  - size_width  : access width in bits selected by a cpu_size code (0 = full word)
package reflet_mem_access_seq_pkg;

  typedef enum logic [2:0] {
    RMS_IDLE     = 3'd0,
    RMS_RD_ISSUE = 3'd1,
    RMS_RD_WAIT  = 3'd2,
    RMS_WRITE    = 3'd3,
    RMS_DONE     = 3'd4
  } rms_state_t;

  localparam logic [1:0] SIZE_FULL = 2'b00;
  localparam logic [1:0] SIZE_32   = 2'b01;
  localparam logic [1:0] SIZE_16   = 2'b10;
  localparam logic [1:0] SIZE_8    = 2'b11;

  localparam int CNT_W = 4;

  function automatic int size_width(input logic [1:0] size);
    case (size)
      SIZE_32: return 32;
      SIZE_16: return 16;
      SIZE_8:  return 8;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/reflet_mem_access_seq_width_mask.sv
// reflet_width_mask: combinational decode of an access size into a narrow flag and
// a low-bit mask. A size is narrow only if it selects fewer bits than the word;
// otherwise the mask is all ones and the access behaves as a full-word access.
//  size    in   2         cpu_size encoding
//  narrow  out  1         1 = access narrower than wordsize
//  mask    out  wordsize  ones over the selected low bits (all ones when full)
module reflet_width_mask
  import reflet_mem_access_seq_pkg::*;
#(
  parameter int wordsize = 16
) (
  input  logic [1:0]          size,
  output logic                narrow,
  output logic [wordsize-1:0] mask
);

  int sel_width;

  assign sel_width = size_width(size);
  assign narrow    = (size != SIZE_FULL) && (sel_width < wordsize);

  for (genvar gi = 0; gi < wordsize; gi++) begin : g_mask
    assign mask[gi] = !narrow || (gi < sel_width);
  end

endmodule

// File: rtl/reflet_mem_access_seq.sv
// reflet_mem_access_seq: sequences CPU accesses onto a single-port synchronous RAM
// with fixed read latency. Full writes go straight to the RAM; reads and narrow
// writes first read the word, narrow writes then merge their low bits into it so
// the upper RAM bits survive.
//  clk, reset            clock, synchronous active-low reset
//  cpu_req/we/size/addr/wdata  request, latched on accept (held until cpu_ready)
//  cpu_rdata, cpu_ready  read result (zero-extended when narrow), one-cycle done pulse
//  ram_en/we/addr/wdata  RAM strobe, write enable, address, write data
//  ram_rdata             RAM read data, valid ram_latency cycles after the strobe
module reflet_mem_access_seq
  import reflet_mem_access_seq_pkg::*;
#(
  parameter int wordsize    = 16,
  parameter int ram_latency = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [1:0]          cpu_size,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  output logic [wordsize-1:0] cpu_rdata,
  output logic                cpu_ready,
  output logic                ram_en,
  output logic                ram_we,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_wdata,
  input  logic [wordsize-1:0] ram_rdata
);

  if (ram_latency < 1 || ram_latency > 15) begin : g_bad_latency
    $error("reflet_mem_access_seq: ram_latency must be in 1..15");
  end

  rms_state_t          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [wordsize-1:0] addr_reg, wdata_reg, rbuf_reg, rdata_reg;
  logic                we_reg;
  logic [1:0]          size_reg;
  logic                accept, capture;

  logic [1:0]          mask_size;
  logic                narrow;
  logic [wordsize-1:0] mask;
  logic [wordsize-1:0] merge;

  // One decoder serves both the accept decision (live cpu_size while IDLE) and the
  // latched size used for the read zero-extend and the write merge.
  assign mask_size = (state_reg == RMS_IDLE) ? cpu_size : size_reg;

  reflet_width_mask #(.wordsize(wordsize)) u_width_mask (
    .size   (mask_size),
    .narrow (narrow),
    .mask   (mask)
  );

  assign merge = (rbuf_reg & ~mask) | (wdata_reg & mask);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      RMS_IDLE: begin
        if (cpu_req) begin
          accept     = 1'b1;
          state_next = (cpu_we && !narrow) ? RMS_WRITE : RMS_RD_ISSUE;
        end
      end
      RMS_RD_ISSUE: begin
        cnt_next   = CNT_W'(ram_latency);
        state_next = RMS_RD_WAIT;
      end
      RMS_RD_WAIT: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = we_reg ? RMS_WRITE : RMS_DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RMS_WRITE: state_next = RMS_DONE;
      RMS_DONE:  state_next = RMS_IDLE;
      default:   state_next = RMS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= RMS_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rbuf_reg  <= '0;
      rdata_reg <= '0;
      we_reg    <= 1'b0;
      size_reg  <= SIZE_FULL;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= cpu_addr;
        wdata_reg <= cpu_wdata;
        we_reg    <= cpu_we;
        size_reg  <= cpu_size;
      end
      if (capture) begin
        rbuf_reg <= ram_rdata;
        if (!we_reg) rdata_reg <= ram_rdata & mask;
      end
    end
  end

  assign cpu_rdata = rdata_reg;
  assign cpu_ready = (state_reg == RMS_DONE);
  assign ram_en    = (state_reg == RMS_RD_ISSUE) || (state_reg == RMS_WRITE);
  assign ram_we    = (state_reg == RMS_WRITE);
  assign ram_addr  = (state_reg != RMS_IDLE) ? addr_reg : '0;
  assign ram_wdata = (state_reg == RMS_WRITE) ? (narrow ? merge : wdata_reg) : '0;

endmodule

// File: tb/tb_reflet_mem_access_seq.sv
module tb_reflet_mem_access_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reflet_mem_access_seq #(.wordsize(32), .ram_latency(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_size  (cpu_size),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM model: read data valid 2 cycles after the sampling edge (three-deep pipe).
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [0:2];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_en && ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    rd_pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr[7:0]] : $urandom;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign ram_rdata = rd_pipe[2];

  // Reference model state
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_read = '0;

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      2'b10:   return 32'h0000_FFFF;
      2'b11:   return 32'h0000_00FF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One complete access; inputs are scrambled after accept to confirm latching.
  task automatic run_access(input logic we, input logic [1:0] size, input logic [7:0] a,
                            input logic [31:0] wd, input string tag);
    logic [31:0] m, exp_rd, exp_mem, wr_val, rd_val;
    logic        nar;
    int          exp_lat, exp_nrd, exp_nwr, cyc, n_rd, n_wr;
    bit          got;
    m       = size_mask(size);
    nar     = (m != 32'hFFFF_FFFF);
    exp_lat = (we && !nar) ? 2 : (we ? 6 : 5);
    exp_nrd = (!we || nar) ? 1 : 0;
    exp_nwr = we ? 1 : 0;
    exp_rd  = we ? last_read : (ref_mem[a] & m);
    exp_mem = we ? (nar ? ((ref_mem[a] & ~m) | (wd & m)) : wd) : ref_mem[a];
    n_rd = 0; n_wr = 0; cyc = 0; got = 0; wr_val = '0; rd_val = '0;

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = {24'd0, a}; cpu_wdata = wd;
    @(posedge clk);
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      cpu_we = 1'($urandom); cpu_size = 2'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      if (ram_en) begin
        if (ram_we) begin n_wr++; wr_val = ram_wdata; end
        else n_rd++;
        checks++;
        if (ram_addr !== {24'd0, a}) begin
          failures++;
          $display("FAIL ram_addr %s: got %h expected %h", tag, ram_addr, {24'd0, a});
        end
      end else begin
        checks++;
        if (ram_we !== 1'b0 || ram_wdata !== 32'd0) begin
          failures++;
          $display("FAIL idle_strobe %s: ram_we=%b ram_wdata=%h expected 0/0", tag, ram_we, ram_wdata);
        end
      end
      if (cpu_ready) begin got = 1; rd_val = cpu_rdata; cpu_req = 1'b0; end
    end

    checks++;
    if (!got) begin
      failures++;
      $display("FAIL timeout %s: no cpu_ready within 40 cycles", tag);
    end
    checks++;
    if (cyc != exp_lat) begin
      failures++;
      $display("FAIL latency %s: got %0d expected %0d", tag, cyc, exp_lat);
    end
    checks++;
    if (n_rd != exp_nrd || n_wr != exp_nwr) begin
      failures++;
      $display("FAIL strobes %s: rd=%0d wr=%0d expected rd=%0d wr=%0d", tag, n_rd, n_wr, exp_nrd, exp_nwr);
    end
    if (we) begin
      checks++;
      if (wr_val !== exp_mem) begin
        failures++;
        $display("FAIL wdata %s: got %h expected %h", tag, wr_val, exp_mem);
      end
    end
    checks++;
    if (rd_val !== exp_rd) begin
      failures++;
      $display("FAIL rdata %s: got %h expected %h", tag, rd_val, exp_rd);
    end
    checks++;
    if (mem[a] !== exp_mem) begin
      failures++;
      $display("FAIL mem %s: got %h expected %h", tag, mem[a], exp_mem);
    end
    ref_mem[a] = exp_mem;
    if (!we) last_read = exp_rd;
    $display("txn %s we=%0d size=%0d addr=%h wdata=%h lat=%0d rdata=%h", tag, we, size, a, wd, cyc, rd_val);
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({cpu_ready, ram_en, ram_we} !== 3'b000 || cpu_rdata !== 32'd0 ||
        ram_addr !== 32'd0 || ram_wdata !== 32'd0) begin
      failures++;
      $display("FAIL %s: ready=%b en=%b we=%b rdata=%h addr=%h wdata=%h expected all 0",
               tag, cpu_ready, ram_en, ram_we, cpu_rdata, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_state");
    reset = 1'b1;
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    $display("txn reset_state ready=%b en=%b rdata=%h", cpu_ready, ram_en, cpu_rdata);
  endtask

  task automatic test_directed;
    preload(8'h10, 32'hDEADBEEF);
    run_access(1'b0, 2'b00, 8'h10, 32'h0, "full_read");
    preload(8'h20, 32'h11223344);
    run_access(1'b1, 2'b11, 8'h20, 32'hAAAAAA55, "byte_rmw");
    preload(8'h30, 32'hCAFEBABE);
    run_access(1'b0, 2'b10, 8'h30, 32'h0, "half_read");
    run_access(1'b1, 2'b01, 8'h31, 32'h12345678, "size01_write");
    run_access(1'b0, 2'b11, 8'h20, 32'h0, "byte_read_back");
  endtask

  task automatic test_reset_mid_access;
    int n_en, n_rdy;
    logic [31:0] keep;
    preload(8'h40, 32'h55667788);
    keep = 32'h55667788;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b11; cpu_addr = 32'h40; cpu_wdata = 32'hFFFFFF99;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_mid_outputs");
    reset = 1'b1; cpu_req = 1'b0;
    last_read = '0;
    n_en = 0; n_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_en) n_en++;
      if (cpu_ready) n_rdy++;
    end
    checks++;
    if (n_en != 0 || n_rdy != 0 || mem[8'h40] !== keep) begin
      failures++;
      $display("FAIL reset_abort: strobes=%0d readys=%0d mem=%h expected 0 0 %h", n_en, n_rdy, mem[8'h40], keep);
    end
    $display("txn reset_mid strobes=%0d readys=%0d mem=%h", n_en, n_rdy, mem[8'h40]);
    run_access(1'b0, 2'b00, 8'h40, 32'h0, "after_reset_read");
  endtask

  task automatic test_back_to_back;
    int cyc, n_rdy, first_at, second_at;
    logic [31:0] r1, r2;
    preload(8'h50, 32'h0BADF00D);
    preload(8'h51, 32'h8BADCAFE);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h50; cpu_wdata = '0;
    @(posedge clk);
    cyc = 0; n_rdy = 0; first_at = 0; second_at = 0; r1 = '0; r2 = '0;
    while (n_rdy < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) begin
        n_rdy++;
        if (n_rdy == 1) begin first_at = cyc; r1 = cpu_rdata; cpu_addr = 32'h51; end
        else begin second_at = cyc; r2 = cpu_rdata; cpu_req = 1'b0; end
      end
    end
    checks++;
    if (first_at != 5 || second_at != 11) begin
      failures++;
      $display("FAIL b2b_timing: ready at %0d,%0d expected 5,11", first_at, second_at);
    end
    checks++;
    if (r1 !== 32'h0BADF00D || r2 !== 32'h8BADCAFE) begin
      failures++;
      $display("FAIL b2b_rdata: got %h,%h expected 0badf00d,8badcafe", r1, r2);
    end
    last_read = 32'h8BADCAFE;
    $display("txn back_to_back ready=%0d,%0d rdata=%h,%h", first_at, second_at, r1, r2);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      run_access(1'($urandom), 2'($urandom), 8'($urandom), $urandom, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
